out_alloc: RTL and testbench

- Per-output-channel switch allocator that sequences one tx channel transmitter.
- Collects packet-send requests from PORTS input buffers and selects one by round-robin among those whose requested channel equals OUT_CHNL.
- Drives the transmitter's sw_req/sw_chnl handshake and routes the winner's buffer read port to the transmitter.
- Holds the grant for the whole packet and releases it when the transmitter drops sw_gnt.

---
 rtl/out_alloc.sv | 112 +++++++++++
 tb/tb_out_alloc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/out_alloc.sv
// Switch allocator for one output channel: round-robin picks an input port whose
// request targets OUT_CHNL, sequences the tx handshake and muxes the winner's buffer.
`timescale 1ns/1ps
module out_alloc #(
  parameter int SIZE         = 8,
  parameter int CHANNEL_BITS = 3,
  parameter int BUFF_BITS    = 3,
  parameter int PORTS        = 5,
  parameter int OUT_CHNL     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PORTS-1:0]                in_req,
  input  logic [PORTS*CHANNEL_BITS-1:0]   in_chnl,
  output logic [PORTS-1:0]                in_gnt,
  output logic [PORTS-1:0]                in_done,
  output logic [BUFF_BITS-1:0]            in_buf_addr,
  input  logic [PORTS*SIZE-1:0]           in_buf_data,
  output logic                            sw_req,
  output logic [CHANNEL_BITS-1:0]         sw_chnl,
  input  logic                            sw_gnt,
  input  logic [BUFF_BITS-1:0]            tx_buf_addr,
  output logic [SIZE-1:0]                 tx_buf_data
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [CHANNEL_BITS-1:0] OUT_C = CHANNEL_BITS'(OUT_CHNL);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr, rr_n, w, w_n, win;
  logic [PORTS-1:0]  gnt_n, done_n, elig;
  logic              req_n, found;

  assign sw_chnl     = OUT_C;
  assign in_buf_addr = tx_buf_addr;
  assign tx_buf_data = (state != IDLE) ? in_buf_data[int'(w)*SIZE +: SIZE] : '0;

  // A port holding in_done is masked so it cannot be re-granted before it has seen completion.
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORTS; i++)
      elig[i] = in_req[i] & (in_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == OUT_C) & ~in_done[i];
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!found && elig[(int'(rr) + k) % PORTS]) begin
        found = 1'b1;
        win   = PW'((int'(rr) + k) % PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= '0;
      w       <= '0;
      in_gnt  <= '0;
      in_done <= '0;
      sw_req  <= 1'b0;
    end else begin
      state   <= state_n;
      rr      <= rr_n;
      w       <= w_n;
      in_gnt  <= gnt_n;
      in_done <= done_n;
      sw_req  <= req_n;
    end
  end

  // sw_gnt is only looked at in REQ/BUSY, so an unknown level while idle is harmless.
  always_comb begin
    state_n = state;
    rr_n    = rr;
    w_n     = w;
    gnt_n   = in_gnt;
    done_n  = '0;
    req_n   = sw_req;
    case (state)
      IDLE: begin
        if (found) begin
          w_n        = win;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          req_n      = 1'b1;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (sw_gnt == 1'b1) begin
          req_n   = 1'b0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (sw_gnt == 1'b0) begin
          gnt_n     = '0;
          done_n[w] = 1'b1;
          rr_n      = (int'(w) == PORTS-1) ? '0 : w + 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_out_alloc.sv
// Directed self-checking bench for out_alloc with PORTS=5, OUT_CHNL=2.
`timescale 1ns/1ps
module tb_out_alloc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_req;
  logic [14:0] in_chnl;
  logic [4:0]  in_gnt, in_done;
  logic [2:0]  in_buf_addr, tx_buf_addr;
  logic [39:0] in_buf_data;
  logic        sw_req, sw_gnt;
  logic [2:0]  sw_chnl;
  logic [7:0]  tx_buf_data;

  int compared = 0;
  int failed   = 0;

  out_alloc #(.SIZE(8), .CHANNEL_BITS(3), .BUFF_BITS(3), .PORTS(5), .OUT_CHNL(2)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_chnl(in_chnl), .in_gnt(in_gnt),
    .in_done(in_done), .in_buf_addr(in_buf_addr), .in_buf_data(in_buf_data),
    .sw_req(sw_req), .sw_chnl(sw_chnl), .sw_gnt(sw_gnt), .tx_buf_addr(tx_buf_addr),
    .tx_buf_data(tx_buf_data)
  );

  always #5 clk = ~clk;

  // Buffer model: port i holds byte i*16 + address.
  always_comb begin
    in_buf_data = '0;
    for (int i = 0; i < 5; i++)
      in_buf_data[i*8 +: 8] = 8'(i*16) + 8'(in_buf_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] req, input logic [14:0] chnl);
    in_req  = req;
    in_chnl = chnl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One packet on an already-requesting port: grant after 1 cycle, tx holds sw_gnt for 'hold' cycles.
  task automatic runPacket(input int port, input int hold);
    logic [4:0] oh;
    oh = 5'b00001 << port;
    step();
    checkOutput($sformatf("pkt%0d_gnt", port), 32'(in_gnt), 32'(oh));
    checkOutput($sformatf("pkt%0d_req", port), 32'(sw_req), 32'd1);
    sw_gnt = 1'b1;
    step();
    checkOutput($sformatf("pkt%0d_req_low", port), 32'(sw_req), 32'd0);
    repeat (hold) step();
    sw_gnt = 1'b0;
    step();
    checkOutput($sformatf("pkt%0d_done", port), 32'(in_done), 32'(oh));
    checkOutput($sformatf("pkt%0d_gnt_rel", port), 32'(in_gnt), 32'd0);
  endtask

  localparam logic [14:0] ALL2 = {3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  initial begin
    reset = 1'b1;
    sw_gnt = 1'bx;
    tx_buf_addr = '0;
    applyStimulus(5'b00000, '0);
    step();
    step();
    reset = 1'b0;
    checkOutput("rst_gnt", 32'(in_gnt), 32'd0);
    checkOutput("rst_req", 32'(sw_req), 32'd0);
    checkOutput("rst_done", 32'(in_done), 32'd0);
    checkOutput("rst_chnl", 32'(sw_chnl), 32'd2);
    checkOutput("rst_txdata", 32'(tx_buf_data), 32'd0);

    // sw_gnt unknown while idle must not disturb anything
    repeat (5) step();
    checkOutput("x_gnt", 32'(in_gnt), 32'd0);
    checkOutput("x_req", 32'(sw_req), 32'd0);
    checkOutput("x_done", 32'(in_done), 32'd0);

    // Single packet from port 2
    sw_gnt = 1'b0;
    applyStimulus(5'b00100, {3'd0, 3'd0, 3'd2, 3'd0, 3'd0});
    step();
    checkOutput("p2_gnt", 32'(in_gnt), 32'h04);
    checkOutput("p2_req", 32'(sw_req), 32'd1);
    checkOutput("p2_txdata_req", 32'(tx_buf_data), 32'h20);
    sw_gnt = 1'b1;
    step();
    checkOutput("p2_req_low", 32'(sw_req), 32'd0);
    for (int a = 0; a < 8; a++) begin
      tx_buf_addr = 3'(a);
      step();
      checkOutput($sformatf("p2_bufaddr%0d", a), 32'(in_buf_addr), 32'(a));
      checkOutput($sformatf("p2_txdata%0d", a), 32'(tx_buf_data), 32'(8'h20 + 8'(a)));
    end
    checkOutput("p2_gnt_held", 32'(in_gnt), 32'h04);
    sw_gnt = 1'b0;
    step();
    checkOutput("p2_done", 32'(in_done), 32'h04);
    checkOutput("p2_gnt_rel", 32'(in_gnt), 32'd0);
    applyStimulus(5'b00000, '0);
    step();
    checkOutput("p2_done_1cyc", 32'(in_done), 32'd0);
    checkOutput("p2_txdata_idle", 32'(tx_buf_data), 32'd0);

    // Port1 asks channel 3, port3 asks channel 2: only port3 wins (rr=3 now)
    applyStimulus(5'b01010, {3'd0, 3'd2, 3'd0, 3'd3, 3'd0});
    runPacket(3, 4);
    applyStimulus(5'b00010, {3'd0, 3'd0, 3'd0, 3'd3, 3'd0});
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("p1_never_req%0d", c), 32'(sw_req), 32'd0);
      checkOutput($sformatf("p1_never_gnt%0d", c), 32'(in_gnt), 32'd0);
    end
    // rr must now be 4: with ports 0 and 4 requesting, port 4 wins
    applyStimulus(5'b10001, ALL2);
    runPacket(4, 2);

    // Fairness with all ports continuously eligible; rr wrapped to 0
    applyStimulus(5'b11111, ALL2);
    runPacket(0, 8);
    runPacket(1, 8);
    runPacket(2, 8);
    runPacket(3, 8);
    runPacket(4, 8);
    runPacket(0, 8);

    // Port0 withdraws its request during REQ; packet still completes
    applyStimulus(5'b00000, ALL2);
    step();
    applyStimulus(5'b00001, ALL2);
    step();
    checkOutput("wd_gnt", 32'(in_gnt), 32'h01);
    applyStimulus(5'b00000, {3'd2, 3'd2, 3'd2, 3'd2, 3'd5});
    step();
    checkOutput("wd_req_hold1", 32'(sw_req), 32'd1);
    step();
    checkOutput("wd_req_hold2", 32'(sw_req), 32'd1);
    checkOutput("wd_gnt_hold", 32'(in_gnt), 32'h01);
    sw_gnt = 1'b1;
    step();
    checkOutput("wd_req_low", 32'(sw_req), 32'd0);
    step();
    step();
    sw_gnt = 1'b0;
    step();
    checkOutput("wd_done", 32'(in_done), 32'h01);
    step();

    // Reset while BUSY on port 3 (rr=1 before reset)
    applyStimulus(5'b01000, ALL2);
    step();
    checkOutput("rb_gnt", 32'(in_gnt), 32'h08);
    sw_gnt = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sw_gnt = 1'b0;
    checkOutput("rb_gnt_clr", 32'(in_gnt), 32'd0);
    checkOutput("rb_req_clr", 32'(sw_req), 32'd0);
    checkOutput("rb_done_clr", 32'(in_done), 32'd0);
    checkOutput("rb_idle_txdata", 32'(tx_buf_data), 32'd0);
    applyStimulus(5'b10001, ALL2);
    step();
    checkOutput("rb_rr0_gnt", 32'(in_gnt), 32'h01);
    checkOutput("rb_rr0_req", 32'(sw_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
